// File: rtl/f_pc_reg.sv
// f_pc_reg: fetch PC/status register with redirect priority and a circular return-address stack.
module f_pc_reg #(
  parameter int PC_W = 64,
  parameter int STAT_W = 4,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic [STAT_W-1:0] F_stat,
  input  logic [PC_W-1:0]   predPC,
  input  logic              mis_valid,
  input  logic [PC_W-1:0]   mis_pc,
  input  logic              ret_valid,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic              call_push,
  input  logic [PC_W-1:0]   call_addr,
  input  logic              ret_pop,
  output logic [PC_W-1:0]   F_predPC,
  output logic [STAT_W-1:0] f_stat,
  output logic [PC_W-1:0]   ras_top,
  output logic              ras_empty,
  output logic              ras_ovf,
  output logic              ras_unf
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [STAT_W-1:0] AOK = STAT_W'(1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic [AW-1:0]     top_q, top_d, wr_idx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_W-1:0]   mem_q [RAS_DEPTH];
  logic [PC_W-1:0]   mem_d [RAS_DEPTH];
  logic redir, halted, en, push, pop, empty, full, rep, adv, dec;

  always_comb begin
    redir  = mis_valid | ret_valid;
    halted = stat_q != AOK;
    pc_d   = mis_valid ? mis_pc : ret_valid ? ret_pc : (halted | F_stall) ? pc_q : predPC;
    stat_d = (redir | (!F_stall & !halted)) ? F_stat : stat_q;
    en     = !F_stall & !redir;
    push   = en & call_push;
    pop    = en & ret_pop;
    empty  = cnt_q == '0;
    full   = cnt_q == FULL;
    // Push+pop on a non-empty stack replaces the top in place; on an empty one it is a plain push.
    rep    = push & pop & !empty;
    adv    = push & !rep;
    dec    = pop & !push & !empty;
    wr_idx = rep ? top_q : top_q + 1'b1;
    top_d  = adv ? top_q + 1'b1 : dec ? top_q - 1'b1 : top_q;
    cnt_d  = (adv & !full) ? cnt_q + 1'b1 : dec ? cnt_q - 1'b1 : cnt_q;
    ovf_d  = ovf_q | (adv & full);
    unf_d  = unf_q | (pop & !push & empty);
    mem_d  = mem_q;
    if (push) mem_d[wr_idx] = call_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      stat_q <= AOK;
      top_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      stat_q <= stat_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign F_predPC  = pc_q;
  assign f_stat    = stat_q;
  assign ras_empty = cnt_q == '0;
  assign ras_top   = ras_empty ? '0 : mem_q[top_q];
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
endmodule

// File: tb/tb_f_pc_reg.sv
// tb_f_pc_reg: table-driven directed vectors for f_pc_reg plus a mid-run reset sequence.
module tb_f_pc_reg;
  logic        clk = 1'b0;
  logic        rst_n, F_stall, mis_valid, ret_valid, call_push, ret_pop;
  logic [3:0]  F_stat, f_stat;
  logic [63:0] predPC, mis_pc, ret_pc, call_addr, F_predPC, ras_top;
  logic        ras_empty, ras_ovf, ras_unf;
  int          n_chk = 0, n_pass = 0;

  f_pc_reg dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .F_stat(F_stat), .predPC(predPC),
    .mis_valid(mis_valid), .mis_pc(mis_pc), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .call_push(call_push), .call_addr(call_addr), .ret_pop(ret_pop),
    .F_predPC(F_predPC), .f_stat(f_stat), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctl;
    logic [3:0]  fst;
    logic [15:0] pred, mpc, rpc, addr, e_pc;
    logic [3:0]  e_st;
    logic [15:0] e_top;
    logic [2:0]  e_fl;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic [15:0] pc, input logic [3:0] st,
                           input logic [15:0] top, input logic [2:0] fl);
    check("F_predPC", idx, F_predPC, {48'h0, pc});
    check("f_stat", idx, {60'h0, f_stat}, {60'h0, st});
    check("ras_top", idx, ras_top, {48'h0, top});
    check("ras_empty", idx, {63'h0, ras_empty}, {63'h0, fl[2]});
    check("ras_ovf", idx, {63'h0, ras_ovf}, {63'h0, fl[1]});
    check("ras_unf", idx, {63'h0, ras_unf}, {63'h0, fl[0]});
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [3:0] fst, input logic [15:0] pred,
                       input logic [15:0] mpc, input logic [15:0] rpc, input logic [15:0] addr);
    {F_stall, mis_valid, ret_valid, call_push, ret_pop} = ctl;
    F_stat    = fst;
    predPC    = {48'h0, pred};
    mis_pc    = {48'h0, mpc};
    ret_pc    = {48'h0, rpc};
    call_addr = {48'h0, addr};
  endtask

  initial begin
    // ctl = {stall, mis_valid, ret_valid, push, pop}; e_fl = {empty, ovf, unf}
    tv.push_back(vec_t'{5'b00000, 4'd1, 16'h000A, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 4'd1, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b00000, 4'd1, 16'h0014, 16'h0000, 16'h0000, 16'h0000, 16'h0014, 4'd1, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b11000, 4'd1, 16'h0020, 16'h0040, 16'h0000, 16'h0000, 16'h0040, 4'd1, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b10000, 4'd1, 16'h0028, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 4'd1, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b00000, 4'd2, 16'h0044, 16'h0000, 16'h0000, 16'h0000, 16'h0044, 4'd2, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b00000, 4'd1, 16'h0048, 16'h0000, 16'h0000, 16'h0000, 16'h0044, 4'd2, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b00000, 4'd1, 16'h004C, 16'h0000, 16'h0000, 16'h0000, 16'h0044, 4'd2, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b00100, 4'd1, 16'h0050, 16'h0000, 16'h0080, 16'h0000, 16'h0080, 4'd1, 16'h0000, 3'b100});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0010, 16'h0100, 4'd1, 16'h0010, 3'b000});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0020, 16'h0100, 4'd1, 16'h0020, 3'b000});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0030, 16'h0100, 4'd1, 16'h0030, 3'b000});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0040, 16'h0100, 4'd1, 16'h0040, 3'b000});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0050, 16'h0100, 4'd1, 16'h0050, 3'b010});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0040, 3'b010});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0030, 3'b010});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0020, 3'b010});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0000, 3'b110});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0000, 3'b111});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0011, 16'h0100, 4'd1, 16'h0011, 3'b011});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0022, 16'h0100, 4'd1, 16'h0022, 3'b011});
    tv.push_back(vec_t'{5'b00011, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0099, 16'h0100, 4'd1, 16'h0099, 3'b011});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0011, 3'b011});
    tv.push_back(vec_t'{5'b00001, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd1, 16'h0000, 3'b111});
    tv.push_back(vec_t'{5'b00011, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0077, 16'h0100, 4'd1, 16'h0077, 3'b011});
    tv.push_back(vec_t'{5'b10010, 4'd1, 16'h0104, 16'h0000, 16'h0000, 16'h0055, 16'h0100, 4'd1, 16'h0077, 3'b011});
    tv.push_back(vec_t'{5'b01010, 4'd1, 16'h0108, 16'h0200, 16'h0000, 16'h0066, 16'h0200, 4'd1, 16'h0077, 3'b011});
    tv.push_back(vec_t'{5'b00010, 4'd1, 16'h0204, 16'h0000, 16'h0000, 16'h0088, 16'h0204, 4'd1, 16'h0088, 3'b011});
    tv.push_back(vec_t'{5'b00000, 4'd3, 16'h0208, 16'h0000, 16'h0000, 16'h0000, 16'h0208, 4'd3, 16'h0088, 3'b011});

    rst_n = 1'b0;
    drive(5'b11011, 4'd4, 16'h0123, 16'h0456, 16'h0789, 16'h0ABC);
    repeat (2) @(posedge clk);
    #1 check_all(-1, 16'h0000, 4'd1, 16'h0000, 3'b100);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].ctl, tv[i].fst, tv[i].pred, tv[i].mpc, tv[i].rpc, tv[i].addr);
      @(posedge clk);
      #1 check_all(i, tv[i].e_pc, tv[i].e_st, tv[i].e_top, tv[i].e_fl);
    end
    // Mid-run reset while halted with RAS entries and sticky flags, against redirect/stall/push.
    rst_n = 1'b0;
    drive(5'b11110, 4'd2, 16'h0300, 16'h0400, 16'h0500, 16'h0600);
    @(posedge clk);
    #1 check_all(100, 16'h0000, 4'd1, 16'h0000, 3'b100);
    rst_n = 1'b1;
    drive(5'b00000, 4'd1, 16'h0300, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1 check_all(101, 16'h0300, 4'd1, 16'h0000, 3'b100);
    drive(5'b00001, 4'd1, 16'h0304, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1 check_all(102, 16'h0304, 4'd1, 16'h0000, 3'b101);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/f_pc_reg.md
F_PC_REG -- requirements
Module: f_pc_reg

Interface
REQ-001 SHALL have parameter PC_W, default 64, PC width in bits.
REQ-002 SHALL have parameter STAT_W, default 4, status code width.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC loaded on reset.
REQ-005 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- F_stall  in  1  hold fetch PC and status this cycle.
- F_stat  in  STAT_W  status of the instruction being fetched.
- predPC  in  PC_W  predicted next PC from fetch.
- mis_valid  in  1  branch-mispredict redirect request.
- mis_pc  in  PC_W  correct PC for a mispredict.
- ret_valid  in  1  return-resolved redirect request.
- ret_pc  in  PC_W  return address resolved by write-back.
- call_push  in  1  push call_addr onto the RAS.
- call_addr  in  PC_W  return address of a fetched call.
- ret_pop  in  1  pop the RAS for a fetched ret.
- F_predPC  out  PC_W  registered fetch PC.
- f_stat  out  STAT_W  registered fetch status.
- ras_top  out  PC_W  current RAS top, 0 when empty.
- ras_empty  out  1  RAS holds no entries.
- ras_ovf  out  1  sticky overflow flag.
- ras_unf  out  1  sticky underflow flag.
REQ-006 SHALL use status encoding AOK=1, HLT=2, ADR=3, INS=4; any value other than 1 is non-AOK.

Function
REQ-007 F_predPC next-value priority, highest first:
- mis_valid -> mis_pc.
- ret_valid -> ret_pc.
- halted -> hold.
- F_stall -> hold.
- else -> predPC.
REQ-008 Halted SHALL be defined as the registered f_stat being non-AOK.
REQ-009 f_stat SHALL load F_stat on any redirect (mis_valid or ret_valid), or when not stalled and not halted; otherwise it SHALL hold.
REQ-010 A redirect SHALL clear the halted condition by reloading both F_predPC and f_stat; a redirect therefore overrides F_stall and halt.
REQ-011 Latency: every output SHALL change only on a rising edge, one cycle after its causing input; no combinational input-to-output path.
REQ-012 RAS SHALL be a circular buffer with a top pointer and an occupancy count in range 0..RAS_DEPTH.
REQ-013 RAS operations SHALL be enabled only when F_stall=0, mis_valid=0 and ret_valid=0; otherwise call_push and ret_pop are ignored.
REQ-014 Enabled push only: write call_addr at top+1, advance top (wrapping modulo RAS_DEPTH), count+1.
REQ-015 Push when count=RAS_DEPTH SHALL overwrite the oldest entry, keep count at RAS_DEPTH, and set ras_ovf.
REQ-016 Enabled pop only, count>0: retreat top (wrapping), count-1.
REQ-017 Pop when count=0 SHALL leave state unchanged and set ras_unf.
REQ-018 Enabled push and pop in the same cycle SHALL replace the top entry with call_addr and leave count unchanged; if count=0 this SHALL act as a push.
REQ-019 ras_top SHALL show the entry at top when count>0, and 0 otherwise; ras_empty SHALL be 1 exactly when count=0.
REQ-020 ras_ovf and ras_unf SHALL stay set until reset.

Reset
REQ-021 On a rising edge with rst_n=0: F_predPC=RESET_PC, f_stat=1 (AOK), RAS count=0, top=0, ras_top=0, ras_empty=1, ras_ovf=0, ras_unf=0.
REQ-022 Reset SHALL override all other inputs, including redirects and stall, and SHALL also apply mid-operation.
REQ-023 RAS entry contents need no reset; they are never visible while count=0.

Verification
REQ-024 Release reset, F_stall=0, predPC=0x0A then 0x14 -> F_predPC shows 0, 0x0A, 0x14 on successive edges; f_stat=1.
REQ-025 F_stall=1 with predPC=0x20 and mis_valid=1, mis_pc=0x40 -> F_predPC=0x40; the next cycle with stall only and no redirect -> F_predPC holds 0x40.
REQ-026 F_stat=2 latched, then predPC varies -> F_predPC and f_stat freeze; then ret_valid=1, ret_pc=0x80, F_stat=1 -> F_predPC=0x80, f_stat=1.
REQ-027 RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_ovf=1, ras_top=0x50; then 4 pops -> ras_top 0x40, 0x30, 0x20, then 0 with ras_empty=1.
REQ-028 Pop on empty -> ras_unf=1, count stays 0; push and pop together with count=2, call_addr=0x99 -> ras_top=0x99, count 2.
REQ-029 Assert rst_n=0 mid-sequence while holding RAS entries and a halt -> all outputs take their REQ-021 values on the next edge.
